// File: rtl/scc_pkg.sv
// Shared fetch/decode definitions: opcodes, default NOP, fetch FSM states and the IF/ID slot payload.
package scc_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned OPC_W        = 7;
  localparam int unsigned IMM16_W      = 16;
  localparam int unsigned PERF_FETCH_W = 32;
  localparam int unsigned PERF_FLUSH_W = 16;

  localparam logic [OPC_W-1:0] OPC_B  = 7'b1100000;
  localparam logic [OPC_W-1:0] OPC_BR = 7'b1100010;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_RSP   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } slot_t;

  // Clear the byte-offset bits of an address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_b_target.sv
// Combinational B-opcode detect and PC-relative target (sign-extended word offset).
module fetch_b_target
  import scc_pkg::*;
(
  input  logic [XLEN-1:0]    pc_i,
  input  logic [OPC_W-1:0]   opcode_i,
  input  logic [IMM16_W-1:0] imm16_i,
  output logic               is_b_c_o,
  output logic [XLEN-1:0]    target_c_o
);

  logic [XLEN-1:0] offset;

  assign is_b_c_o   = (opcode_i == OPC_B);
  assign offset     = {{14{imm16_i[15]}}, imm16_i, 2'b00};
  assign target_c_o = pc_i + offset;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, one outstanding IM request, local B resolution, redirects.
// Optional performance counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl
  import scc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        im_req_o,
  output logic [31:0] im_addr_o,
  input  logic        im_ready_i,
  input  logic        im_valid_i,
  input  logic [31:0] im_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [15:0] perf_flush_o
`endif
);

  localparam logic [XLEN-1:0] PC_INIT = word_align(RESET_PC);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  slot_t           slot_q, slot_d;
  logic            run_q;
  logic            slot_free;
  logic            req_c;
  logic            accept;
  logic            is_b;
  logic [XLEN-1:0] b_target;

  fetch_b_target u_b_target (
    .pc_i       (pc_q),
    .opcode_i   (im_rdata_i[31:25]),
    .imm16_i    (im_rdata_i[15:0]),
    .is_b_c_o   (is_b),
    .target_c_o (b_target)
  );

  // run_q keeps the request line low while reset is asserted and for the release cycle.
  assign slot_free = !slot_q.valid || !stall_i;
  assign req_c     = run_q && (state_q == S_REQ) && slot_free;
  assign accept    = req_c && im_ready_i;

  assign im_req_o      = req_c;
  assign im_addr_o     = pc_q;
  assign instr_o       = slot_q.instr;
  assign instr_valid_o = slot_q.valid;
  assign pc_o          = slot_q.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= PC_INIT;
      slot_q  <= '{valid: 1'b0, pc: PC_INIT, instr: NOP_INSTR};
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      slot_q  <= slot_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    slot_d  = slot_q;

    if (slot_q.valid && !stall_i) begin
      slot_d.valid = 1'b0;
      slot_d.instr = NOP_INSTR;
    end

    case (state_q)
      S_REQ: begin
        if (accept) state_d = S_RSP;
      end
      S_RSP: begin
        if (im_valid_i) begin
          state_d = S_REQ;
          if (is_b) begin
            pc_d = b_target;
          end else begin
            slot_d = '{valid: 1'b1, pc: pc_q, instr: im_rdata_i};
            pc_d   = pc_q + 32'd4;
          end
        end
      end
      S_DRAIN: begin
        if (im_valid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // Redirect wins over everything; a response arriving this cycle is the stale one being dropped.
    if (redirect_i) begin
      pc_d   = word_align(redirect_pc_i);
      slot_d = '{valid: 1'b0, pc: slot_q.pc, instr: NOP_INSTR};
      case (state_q)
        S_REQ:          state_d = accept ? S_DRAIN : S_REQ;
        S_RSP, S_DRAIN: state_d = im_valid_i ? S_REQ : S_DRAIN;
        default:        state_d = S_REQ;
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [PERF_FETCH_W-1:0] perf_fetch_q;
  logic [PERF_FLUSH_W-1:0] perf_flush_q;
  logic                    deliver_c;
  logic                    flush_evt_c;

  assign deliver_c   = (state_q == S_RSP) && im_valid_i && !is_b && !redirect_i;
  assign flush_evt_c = redirect_i && (slot_q.valid || (state_q != S_REQ) || accept);

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (deliver_c && (perf_fetch_q != '1)) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (flush_evt_c && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural IM and request/slot scoreboards.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        im_req_o;
  logic [31:0] im_addr_o;
  logic        im_ready_i;
  logic        im_valid_i;
  logic [31:0] im_rdata_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;

  int checks = 0;
  int errors = 0;
  int im_lat = 1;

  logic [31:0] sb_req[$];
  logic [63:0] sb_slot[$];

  fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .im_req_o      (im_req_o),
    .im_addr_o     (im_addr_o),
    .im_ready_i    (im_ready_i),
    .im_valid_i    (im_valid_i),
    .im_rdata_i    (im_rdata_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .pc_o          (pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h1234_0001;
    if (a == 32'h0000_0008) return 32'hC000_FFFE;
    return {8'h10, a[23:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_slot(input logic [31:0] pc, input logic [31:0] instr);
    sb_slot.push_back({pc, instr});
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s: instr_valid_o observed 0 for 20 cycles, expected 1", tag);
    end
  endtask

  // Let decode take the slot for exactly one cycle; fetch must resume in that same cycle.
  task automatic next_instr(input string tag);
    wait_valid(tag);
    stall_i = 1'b0;
    #1;
    check({tag, "_req"}, 32'(im_req_o), 32'd1);
    @(posedge clk);
    #1;
    stall_i = 1'b1;
  endtask

  // IM model (fixed latency, always ready) plus scoreboard monitor, sampled on the falling edge.
  initial begin
    logic        acc;
    logic [31:0] acc_addr;
    logic        pend;
    logic [31:0] p_addr;
    int          cnt;
    logic [63:0] e;
    im_valid_i = 1'b0;
    im_rdata_i = 32'h0;
    pend       = 1'b0;
    p_addr     = 32'h0;
    cnt        = 0;
    forever begin
      @(negedge clk);
      acc      = rst_n && im_req_o && im_ready_i;
      acc_addr = im_addr_o;
      if (acc) begin
        checks++;
        assert (sb_req.size() > 0) else begin
          errors++;
          $error("FAIL im_req_unexpected: observed request at %h, expected none", im_addr_o);
        end
        if (sb_req.size() > 0) check("im_addr", im_addr_o, sb_req.pop_front());
      end
      if (rst_n && instr_valid_o && !stall_i && !redirect_i) begin
        checks++;
        assert (sb_slot.size() > 0) else begin
          errors++;
          $error("FAIL slot_unexpected: observed %h at pc %h, expected none", instr_o, pc_o);
        end
        if (sb_slot.size() > 0) begin
          e = sb_slot.pop_front();
          check("slot_instr", instr_o, e[31:0]);
          check("slot_pc", pc_o, e[63:32]);
        end
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend       = 1'b0;
        im_valid_i = 1'b0;
      end else begin
        if (acc) begin
          pend   = 1'b1;
          p_addr = acc_addr;
          cnt    = im_lat - 1;
        end
        if (pend && cnt == 0) begin
          im_valid_i = 1'b1;
          im_rdata_i = mem_rd(p_addr);
          pend       = 1'b0;
        end else begin
          im_valid_i = 1'b0;
          if (pend) cnt--;
        end
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog: observed no finish by 200000, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    stall_i       = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    im_ready_i    = 1'b1;
    repeat (2) tick();
    check("rst_req", 32'(im_req_o), 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_pc", pc_o, 32'h0);

    // First fetch after reset, then sequential and B at 0x8 back to 0x0.
    sb_req.push_back(32'h0);
    sb_req.push_back(32'h4);
    push_slot(32'h0, 32'h1234_0001);
    rst_n = 1'b1;
    next_instr("first");
    push_slot(32'h4, 32'h1000_0004);
    sb_req.push_back(32'h8);
    sb_req.push_back(32'h0);
    next_instr("seq4");
    push_slot(32'h0, 32'h1234_0001);
    sb_req.push_back(32'h4);
    next_instr("after_b");

    // Stall with a valid slot: outputs hold, no requests.
    wait_valid("stall_fill");
    for (int i = 0; i < 5; i++) begin
      check("stall_instr", instr_o, 32'h1000_0004);
      check("stall_pc", pc_o, 32'h4);
      check("stall_valid", 32'(instr_valid_o), 32'd1);
      check("stall_noreq", 32'(im_req_o), 32'd0);
      tick();
    end
    push_slot(32'h4, 32'h1000_0004);
    sb_req.push_back(32'h8);
    sb_req.push_back(32'h0);
    next_instr("stall_release");

    // Redirect while waiting for a response (two-cycle IM).
    wait_valid("b_refill");
    im_lat = 2;
    push_slot(32'h0, 32'h1234_0001);
    sb_req.push_back(32'h4);
    next_instr("pre_rsp_redirect");
    redirect_pc_i = 32'h103;
    redirect_i    = 1'b1;
    sb_req.push_back(32'h100);
    tick();
    redirect_i = 1'b0;
    check("rr_flush_valid", 32'(instr_valid_o), 32'd0);
    check("rr_flush_instr", instr_o, 32'h0);
    check("rr_drain_noreq", 32'(im_req_o), 32'd0);
    tick();
    check("rr_discard_valid", 32'(instr_valid_o), 32'd0);
    check("rr_req", 32'(im_req_o), 32'd1);
    check("rr_addr", im_addr_o, 32'h100);
    push_slot(32'h100, 32'h1000_0100);
    sb_req.push_back(32'h104);
    next_instr("after_drain");

    // Redirect flushing a valid, stalled slot.
    wait_valid("slot_104");
    redirect_pc_i = 32'h200;
    redirect_i    = 1'b1;
    im_lat        = 1;
    sb_req.push_back(32'h200);
    tick();
    redirect_i = 1'b0;
    check("sf_valid", 32'(instr_valid_o), 32'd0);
    check("sf_instr", instr_o, 32'h0);
    check("sf_req", 32'(im_req_o), 32'd1);
    check("sf_addr", im_addr_o, 32'h200);

    // Redirect coinciding with im_valid_i.
    push_slot(32'h200, 32'h1000_0200);
    sb_req.push_back(32'h204);
    next_instr("pre_rv");
    redirect_pc_i = 32'h300;
    redirect_i    = 1'b1;
    sb_req.push_back(32'h300);
    tick();
    redirect_i = 1'b0;
    check("rv_valid", 32'(instr_valid_o), 32'd0);
    check("rv_req", 32'(im_req_o), 32'd1);
    check("rv_addr", im_addr_o, 32'h300);
    push_slot(32'h300, 32'h1000_0300);
    sb_req.push_back(32'h304);
    next_instr("after_rv");

    // PC wrap-around at the top of the address space.
    wait_valid("slot_304");
    redirect_pc_i = 32'hFFFF_FFFC;
    redirect_i    = 1'b1;
    im_lat        = 2;
    sb_req.push_back(32'hFFFF_FFFC);
    tick();
    redirect_i = 1'b0;
    push_slot(32'hFFFF_FFFC, 32'h10FF_FFFC);
    sb_req.push_back(32'h0);
    next_instr("wrap");
    check("wrap_pc_hold", pc_o, 32'hFFFF_FFFC);

    // Asynchronous reset pulse while a response is pending.
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(im_req_o), 32'd0);
    check("arst_valid", 32'(instr_valid_o), 32'd0);
    check("arst_instr", instr_o, 32'h0);
    check("arst_pc", pc_o, 32'h0);
    check("arst_addr", im_addr_o, 32'h0);
    repeat (3) tick();
    im_lat = 1;
    sb_req.push_back(32'h0);
    sb_req.push_back(32'h4);
    push_slot(32'h0, 32'h1234_0001);
    rst_n = 1'b1;
    next_instr("post_reset");
    wait_valid("final_fill");
    check("final_pc", pc_o, 32'h4);
    check("final_instr", instr_o, 32'h1000_0004);
    repeat (3) tick();
    check("req_q_drained", 32'(sb_req.size()), 32'd0);
    check("slot_q_drained", 32'(sb_slot.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the instruction-fetch stage. It owns the PC and issues one outstanding instruction-memory (IM) request at a time. It resolves unconditional B locally, so decode never sees a B, and applies redirects from later stages for conditional branches and BR. It delivers one instruction per handshake into the IF/ID slot and honours decode stalls.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
NOP_INSTR, 32'h0000_0000, encoding driven on instr_o when the slot is empty or flushed

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
stall_i  in  1  decode cannot accept; instr_o/pc_o/instr_valid_o hold
redirect_i  in  1  conditional branch taken or BR resolved downstream; flush and reload PC
redirect_pc_i  in  32  redirect target byte address; bits [1:0] ignored, treated as 0
im_req_o  out  1  IM request valid
im_addr_o  out  32  IM word-aligned byte address
im_ready_i  in  1  IM accepts request this cycle
im_valid_i  in  1  IM response valid
im_rdata_i  in  32  IM response instruction
instr_o  out  32  instruction to decode
instr_valid_o  out  1  instr_o valid
pc_o  out  32  byte address of instr_o

Behaviour:
- Reset (async assert): pc_q=RESET_PC, state=S_REQ, im_req_o=0 while rst_n=0, instr_o=NOP_INSTR, instr_valid_o=0, pc_o=RESET_PC. IM shares rst_n, so no response survives reset.
- States: S_REQ, S_RSP, S_DRAIN.
- S_REQ: im_req_o=1, im_addr_o=pc_q, only when the slot is free, i.e. instr_valid_o=0 or stall_i=0. On im_ready_i&im_req_o, go to S_RSP.
- S_RSP: im_req_o=0. On im_valid_i:
  - If im_rdata_i[31:25]==7'b1100000 (B): pc_q <= pc_q + (sext(im_rdata_i[15:0])<<2). The B is not forwarded and the slot is unchanged. Go to S_REQ.
  - Otherwise: instr_o <= im_rdata_i, pc_o <= pc_q, instr_valid_o <= 1, pc_q <= pc_q+4. Go to S_REQ.
- Slot consumption: the slot is consumed in any cycle with instr_valid_o=1 and stall_i=0. If nothing new is loaded that cycle, instr_valid_o <= 0 and instr_o <= NOP_INSTR.
- Redirect has highest priority and overrides stall_i:
  - Effects: pc_q <= {redirect_pc_i[31:2],2'b00}; instr_valid_o <= 0; instr_o <= NOP_INSTR.
  - In S_RSP without im_valid_i, go to S_DRAIN. In S_RSP with im_valid_i, the response is discarded and the next state is S_REQ.
  - In S_REQ with a request accepted the same cycle, go to S_DRAIN. In S_REQ with no acceptance, stay in S_REQ.
  - In S_DRAIN, stay in S_DRAIN and update the target.
- S_DRAIN: im_req_o=0. Discard the next im_valid_i response, then go to S_REQ.
- Redirect latency: the first request at the new PC is issued in the cycle after the redirect when no response is pending.
- Fetch latency: request accept to instr_valid_o is 1 cycle after im_valid_i (registered output).
- Throughput: at most one instruction per 2 cycles with zero-wait IM. Back-to-back pipelining is not supported.
- Arithmetic: all PC arithmetic is 32-bit, modulo 2^32, with wrap-around permitted. pc_q[1:0] is always 0.
- B offset 0 (branch-to-self) refetches the same address indefinitely; this is legal.
- im_valid_i in S_REQ is a protocol error and is ignored.

Optional Feature:
FETCH_CTRL_PERF_EN
- Defined: adds outputs perf_fetch_o[31:0] and perf_flush_o[15:0].
  - perf_fetch_o counts instructions delivered to the slot.
  - perf_flush_o counts redirect_i cycles that discarded a valid slot or a pending or arriving response.
  - Both counters saturate and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package scc_pkg: OPC_B=7'b1100000, OPC_BR=7'b1100010, default NOP_INSTR, and the fetch state typedef (S_REQ, S_RSP, S_DRAIN).
- One natural sub-module: fetch_b_target. It is combinational: B opcode detect plus sign-extended shifted target add. It is reusable by decode for conditional-branch targets.

Test Plan:
- Reset release with zero-wait IM returning 32'h1234_0001 at 0x0 → first im_addr_o=0x0; instr_o=32'h1234_0001, pc_o=0x0, instr_valid_o=1; next im_addr_o=0x4.
- B at 0x8 with imm16=16'hFFFE → B never appears on instr_o; next im_addr_o=0x0.
- Hold stall_i=1 for 5 cycles with the slot valid → instr_o/pc_o stable; no further im_req_o after the next response fills the slot; fetch resumes the cycle stall_i drops.
- redirect_i with redirect_pc_i=0x103 while in S_RSP → slot flushed to NOP, next response discarded, next im_addr_o=0x100.
- redirect_i in the same cycle as im_valid_i → response discarded; im_addr_o=target the next cycle.
- pc_q=0xFFFF_FFFC, sequential fetch → next im_addr_o=0x0; async rst_n pulse mid S_RSP → outputs return to reset values immediately.
